// File: rtl/fighter_state_ctrl.sv
// Per-player fighter controller: walk, jump physics, punch, L>D>R>ATK special and hit-stun,
// all advancing on the game tick and feeding the sprite renderer.
module fighter_state_ctrl #(
  parameter int unsigned X_START  = 20,
  parameter int unsigned X_MIN    = 8,
  parameter int unsigned X_MAX    = 88,
  parameter int unsigned Y_GROUND = 32,
  parameter int unsigned STEP     = 2,
  parameter int unsigned JUMP_V   = 6,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned PUNCH_T  = 3,
  parameter int unsigned SP_T     = 4,
  parameter int unsigned INJ_T    = 3,
  parameter int unsigned KNOCK    = 4,
  parameter int unsigned CMB_WIN  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic       hit_in,
  input  logic [6:0] opp_x,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic [1:0] move_state,
  output logic [2:0] character_state,
  output logic       mirror,
  output logic       attack_hit,
  output logic       special_fire
);

  localparam int unsigned CNT_W = $clog2(PUNCH_T + SP_T + INJ_T);
  localparam int unsigned WIN_W = $clog2(CMB_WIN + 1);

  localparam logic [1:0] MS_IDLE = 2'b00;
  localparam logic [1:0] MS_FWD  = 2'b01;
  localparam logic [1:0] MS_BACK = 2'b10;

  typedef enum logic [2:0] {
    ST_NORMAL  = 3'b000,
    ST_PUNCH   = 3'b001,
    ST_SP0     = 3'b010,
    ST_INJURED = 3'b100
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic signed [4:0] vy;
  logic              hit_pend;
  logic [1:0]        combo, combo_nxt;
  logic [WIN_W-1:0]  cmb_cnt, cmb_cnt_nxt;
  logic [4:0]        btn_now, btn_prev, press;
  logic signed [7:0] ny;
  logic              land;

  assign character_state = state;

  // {attack, down, up, right, left}
  assign btn_now = {btn_attack, btn_down, btn_up, btn_right, btn_left};
  assign press   = btn_now & ~btn_prev;

  function automatic logic [6:0] sat_add(input logic [6:0] v, input logic [6:0] d);
    logic [7:0] s;
    s = {1'b0, v} + {1'b0, d};
    return (s > 8'(X_MAX)) ? 7'(X_MAX) : s[6:0];
  endfunction

  function automatic logic [6:0] sat_sub(input logic [6:0] v, input logic [6:0] d);
    return ({1'b0, v} < (8'(X_MIN) + {1'b0, d})) ? 7'(X_MIN) : (v - d);
  endfunction

  // Next airborne height; landing when it reaches or passes the ground line
  always_comb begin
    ny   = signed'({1'b0, y}) - 8'(vy);
    land = (ny >= signed'(8'(Y_GROUND)));
  end

  // Combo tracker: a left press always restarts the sequence
  always_comb begin
    combo_nxt   = combo;
    cmb_cnt_nxt = cmb_cnt;
    if (press[0]) begin
      combo_nxt   = 2'd1;
      cmb_cnt_nxt = '0;
    end else if (|press[3:1]) begin
      cmb_cnt_nxt = '0;
      if (combo == 2'd1 && press[3:1] == 3'b100)      combo_nxt = 2'd2;
      else if (combo == 2'd2 && press[3:1] == 3'b001) combo_nxt = 2'd3;
      else                                            combo_nxt = 2'd0;
    end else if (combo != 2'd0) begin
      if (cmb_cnt == WIN_W'(CMB_WIN - 1)) begin
        combo_nxt   = 2'd0;
        cmb_cnt_nxt = '0;
      end else begin
        cmb_cnt_nxt = cmb_cnt + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_NORMAL;
      cnt          <= '0;
      x            <= 7'(X_START);
      y            <= 7'(Y_GROUND);
      vy           <= '0;
      in_air       <= 1'b0;
      move_state   <= MS_IDLE;
      mirror       <= 1'b0;
      attack_hit   <= 1'b0;
      special_fire <= 1'b0;
      hit_pend     <= 1'b0;
      combo        <= '0;
      cmb_cnt      <= '0;
      btn_prev     <= '0;
    end else begin
      attack_hit   <= 1'b0;
      special_fire <= 1'b0;
      if (tick) hit_pend <= hit_in;
      else if (hit_in) hit_pend <= 1'b1;

      if (tick) begin
        btn_prev <= btn_now;
        if (in_air) begin
          if (land) begin
            y      <= 7'(Y_GROUND);
            in_air <= 1'b0;
            vy     <= '0;
          end else begin
            y  <= ny[6:0];
            vy <= vy - 5'(GRAVITY);
          end
        end

        // A hit preempts everything except an ongoing stun
        if (hit_pend && state != ST_INJURED) begin
          state      <= ST_INJURED;
          cnt        <= '0;
          move_state <= MS_IDLE;
          combo      <= '0;
          cmb_cnt    <= '0;
          x          <= mirror ? sat_sub(x, 7'(KNOCK)) : sat_add(x, 7'(KNOCK));
        end else begin
          case (state)
            ST_NORMAL: begin
              mirror <= (opp_x < x);
              if (press[4] && !in_air) begin
                state      <= (combo == 2'd3) ? ST_SP0 : ST_PUNCH;
                cnt        <= '0;
                move_state <= MS_IDLE;
                combo      <= '0;
                cmb_cnt    <= '0;
              end else begin
                if (btn_left ^ btn_right) begin
                  x          <= btn_right ? sat_add(x, 7'(STEP)) : sat_sub(x, 7'(STEP));
                  move_state <= (btn_right ^ mirror) ? MS_FWD : MS_BACK;
                end else begin
                  move_state <= MS_IDLE;
                end
                if (press[2] && !in_air) begin
                  in_air <= 1'b1;
                  vy     <= 5'(JUMP_V);
                end
                combo   <= combo_nxt;
                cmb_cnt <= cmb_cnt_nxt;
              end
            end
            ST_PUNCH: begin
              if (cnt == CNT_W'(PUNCH_T - 1)) begin
                state <= ST_NORMAL;
                cnt   <= '0;
              end else begin
                cnt        <= cnt + CNT_W'(1);
                attack_hit <= (cnt == '0);
              end
            end
            ST_SP0: begin
              if (cnt == CNT_W'(SP_T - 1)) begin
                state        <= ST_NORMAL;
                cnt          <= '0;
                special_fire <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            ST_INJURED: begin
              if (cnt == CNT_W'(INJ_T - 1)) begin
                state <= ST_NORMAL;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: begin
              state <= ST_NORMAL;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// Bench for fighter_state_ctrl: directed vector table, hand sequences for combo/hit corners,
// and randomized play against a tick-level behavioural model.
module tb_fighter_state_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, btn_left, btn_right, btn_up, btn_down, btn_attack, hit_in;
  logic [6:0] opp_x;
  logic [6:0] x, y;
  logic       in_air, mirror, attack_hit, special_fire;
  logic [1:0] move_state;
  logic [2:0] character_state;

  int checks = 0;
  int errors = 0;

  localparam bit [4:0] B_L = 5'b00001;
  localparam bit [4:0] B_R = 5'b00010;
  localparam bit [4:0] B_U = 5'b00100;
  localparam bit [4:0] B_D = 5'b01000;
  localparam bit [4:0] B_A = 5'b10000;

  fighter_state_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_attack(btn_attack),
    .hit_in(hit_in), .opp_x(opp_x),
    .x(x), .y(y), .in_air(in_air), .move_state(move_state),
    .character_state(character_state), .mirror(mirror),
    .attack_hit(attack_hit), .special_fire(special_fire)
  );

  always #5 clk = ~clk;

  // Behavioural model: phases are timed from the tick they started on
  int m_x, m_y, m_vy, m_ms, m_cs, m_stage, m_last_adv, m_start, m_now;
  bit m_air, m_mir, m_ah, m_sf, m_pend;
  bit [4:0] m_prev;

  task automatic model_reset();
    m_x = 20; m_y = 32; m_vy = 0; m_ms = 0; m_cs = 0; m_stage = 0;
    m_last_adv = 0; m_start = 0; m_now = 0;
    m_air = 0; m_mir = 0; m_ah = 0; m_sf = 0; m_pend = 0; m_prev = '0;
  endtask

  task automatic model_tick();
    bit [4:0] b, pr;
    bit hit, air0, old_mir;
    int ny, k;
    b  = {btn_attack, btn_down, btn_up, btn_right, btn_left};
    pr = b & ~m_prev;
    m_prev = b;
    hit = m_pend; m_pend = 0;
    m_ah = 0; m_sf = 0;
    m_now++;
    air0 = m_air;
    if (m_air) begin
      ny = m_y - m_vy;
      m_vy = m_vy - 1;
      if (ny >= 32) begin m_y = 32; m_air = 0; m_vy = 0; end
      else m_y = ny;
    end
    k = m_now - m_start;
    if (hit && m_cs != 4) begin
      m_cs = 4; m_start = m_now; m_ms = 0; m_stage = 0;
      if (!m_mir) m_x = (m_x + 4 > 88) ? 88 : m_x + 4;
      else        m_x = (m_x - 4 < 8) ? 8 : m_x - 4;
    end else if (m_cs == 0) begin
      old_mir = m_mir;
      m_mir = (int'(opp_x) < m_x);
      if (pr[4] && !air0) begin
        m_cs = (m_stage == 3) ? 2 : 1;
        m_start = m_now; m_ms = 0; m_stage = 0;
      end else begin
        if (b[0] != b[1]) begin
          if (b[1]) m_x = (m_x + 2 > 88) ? 88 : m_x + 2;
          else      m_x = (m_x - 2 < 8) ? 8 : m_x - 2;
          m_ms = ((b[1] && !old_mir) || (b[0] && old_mir)) ? 1 : 2;
        end else m_ms = 0;
        if (pr[2] && !air0) begin m_air = 1; m_vy = 6; end
        if (pr[0]) begin m_stage = 1; m_last_adv = m_now; end
        else if (pr[3:1] != 3'b000) begin
          if (m_stage == 1 && pr[3:1] == 3'b100)      begin m_stage = 2; m_last_adv = m_now; end
          else if (m_stage == 2 && pr[3:1] == 3'b001) begin m_stage = 3; m_last_adv = m_now; end
          else m_stage = 0;
        end else if (m_stage != 0 && m_now - m_last_adv >= 8) m_stage = 0;
      end
    end else if (m_cs == 1) begin
      if (k == 3) m_cs = 0;
      else if (k == 1) m_ah = 1;
    end else if (m_cs == 2) begin
      if (k == 4) begin m_cs = 0; m_sf = 1; end
    end else if (m_cs == 4) begin
      if (k == 3) m_cs = 0;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, int ex, int ey, int eair, int ems, int ecs,
                           int emir, int eah, int esf);
    chk({tag, ".x"}, int'(x), ex);
    chk({tag, ".y"}, int'(y), ey);
    chk({tag, ".in_air"}, int'(in_air), eair);
    chk({tag, ".move_state"}, int'(move_state), ems);
    chk({tag, ".character_state"}, int'(character_state), ecs);
    chk({tag, ".mirror"}, int'(mirror), emir);
    chk({tag, ".attack_hit"}, int'(attack_hit), eah);
    chk({tag, ".special_fire"}, int'(special_fire), esf);
  endtask

  task automatic check_model(string tag);
    check_all(tag, m_x, m_y, int'(m_air), m_ms, m_cs, int'(m_mir), int'(m_ah), int'(m_sf));
  endtask

  task automatic set_btn(bit [4:0] b);
    btn_left = b[0]; btn_right = b[1]; btn_up = b[2]; btn_down = b[3]; btn_attack = b[4];
  endtask

  // One idle clock (pulses must be low) then one tick
  task automatic step();
    @(posedge clk); #1;
    chk("idle.attack_hit", int'(attack_hit), 0);
    chk("idle.special_fire", int'(special_fire), 0);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    model_tick();
  endtask

  task automatic gap_hit();
    hit_in = 1'b1;
    @(posedge clk); #1;
    hit_in = 1'b0;
    m_pend = 1;
  endtask

  task automatic do_reset(string tag);
    tick = 1'b0; hit_in = 1'b0;
    reset = 1'b1;
    #3;
    model_reset();
    check_all(tag, 20, 32, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit [4:0] btn;
    int ex, ey, eair, ems, ecs, emir, eah, esf;
  } vec_t;

  function automatic vec_t mk(bit [4:0] b, int ex, int ey, int eair, int ems, int ecs,
                              int emir, int eah, int esf);
    vec_t v;
    v.btn = b; v.ex = ex; v.ey = ey; v.eair = eair; v.ems = ems;
    v.ecs = ecs; v.emir = emir; v.eah = eah; v.esf = esf;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    int   jy[12];
    jy = '{26, 21, 17, 14, 12, 11, 11, 12, 14, 17, 21, 26};

    // Walk right from reset, tap jump, then tap attack
    for (int i = 1; i <= 5; i++) tv.push_back(mk(B_R, 20 + 2 * i, 32, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(5'b0, 30, 32, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(B_U, 30, 32, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) tv.push_back(mk(5'b0, 30, jy[i], 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(5'b0, 30, 32, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(B_A, 30, 32, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(5'b0, 30, 32, 0, 0, 1, 0, 1, 0));
    tv.push_back(mk(5'b0, 30, 32, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(5'b0, 30, 32, 0, 0, 0, 0, 0, 0));

    set_btn(5'b0); opp_x = 7'd90; tick = 1'b0; hit_in = 1'b0;
    do_reset("reset0");
    for (int i = 0; i < tv.size(); i++) begin
      set_btn(tv[i].btn);
      step();
      check_all($sformatf("vec%0d", i), tv[i].ex, tv[i].ey, tv[i].eair, tv[i].ems,
                tv[i].ecs, tv[i].emir, tv[i].eah, tv[i].esf);
    end

    // Right clamp at X_MAX
    do_reset("reset_t2");
    set_btn(B_R);
    repeat (33) step();
    chk("t2_x86", int'(x), 86);
    for (int i = 0; i < 3; i++) begin step(); chk("t2_sat", int'(x), 88); end
    set_btn(5'b0);

    // Special with 2-tick gaps, then exact 8-tick gap, then 9-tick gap
    do_reset("reset_t5");
    set_btn(B_L); step(); set_btn(5'b0); step();
    set_btn(B_D); step(); set_btn(5'b0); step();
    set_btn(B_R); step(); set_btn(5'b0); step();
    set_btn(B_A); step(); set_btn(5'b0);
    chk("t5_enter_sp", int'(character_state), 2);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t5_sp_state%0d", k), int'(character_state), (k < 4) ? 2 : 0);
      chk($sformatf("t5_fire%0d", k), int'(special_fire), (k == 4) ? 1 : 0);
    end
    set_btn(B_L); step(); set_btn(5'b0); repeat (7) step();
    set_btn(B_D); step(); set_btn(5'b0); step();
    set_btn(B_R); step(); set_btn(5'b0); step();
    set_btn(B_A); step(); set_btn(5'b0);
    chk("t5_gap8_sp", int'(character_state), 2);
    repeat (4) step();
    set_btn(B_L); step(); set_btn(5'b0); repeat (8) step();
    set_btn(B_D); step(); set_btn(5'b0); step();
    set_btn(B_R); step(); set_btn(5'b0); step();
    set_btn(B_A); step(); set_btn(5'b0);
    chk("t5_gap9_punch", int'(character_state), 1);
    repeat (3) step();

    // Hit mid-punch: knockback, no attack pulse, second hit ignored
    do_reset("reset_t6");
    set_btn(B_R); repeat (10) step(); set_btn(5'b0); step();
    chk("t6_x40", int'(x), 40);
    set_btn(B_A); step(); set_btn(5'b0);
    gap_hit(); step();
    check_all("t6_inj", 44, 32, 0, 0, 4, 0, 0, 0);
    gap_hit(); step();
    check_all("t6_inj2", 44, 32, 0, 0, 4, 0, 0, 0);
    step();
    chk("t6_inj3", int'(character_state), 4);
    step();
    check_all("t6_normal", 44, 32, 0, 0, 0, 0, 0, 0);

    // Reset mid-air and with a hit pending
    do_reset("reset_air0");
    set_btn(B_U); step(); set_btn(5'b0); repeat (3) step();
    chk("air_before_rst", int'(in_air), 1);
    do_reset("reset_air");
    step();
    check_all("after_air_rst", 20, 32, 0, 0, 0, 0, 0, 0);
    gap_hit();
    do_reset("reset_hit");
    step();
    chk("hit_dropped", int'(character_state), 0);

    // Randomized play against the model
    do_reset("reset_rand");
    opp_x = 7'($urandom_range(0, 127));
    for (int i = 0; i < 1500; i++) begin
      bit [4:0] b;
      if ($urandom_range(0, 9) == 0) opp_x = 7'($urandom_range(0, 127));
      b[0] = ($urandom_range(0, 99) < 35);
      b[1] = ($urandom_range(0, 99) < 35);
      b[2] = ($urandom_range(0, 99) < 15);
      b[3] = ($urandom_range(0, 99) < 25);
      b[4] = ($urandom_range(0, 99) < 12);
      set_btn(b);
      if ($urandom_range(0, 24) == 0) gap_hit();
      if ($urandom_range(0, 399) == 0) do_reset("rand_reset");
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
